// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS top view and the boot-time instruction loader.
package mips_pkg;

  // Loader protocol states: length header, payload words, trailing checksum, terminal states.
  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } loader_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LEN_W      = 16;

endpackage

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: unpacks a length-prefixed byte stream into 32-bit
// big-endian words, writes them at word-aligned byte addresses and releases the core
// only once the image checksum has verified.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_run,
  output logic              done,
  output logic              error
);

  loader_state_t    state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [23:0]      shift_q, shift_d;
  logic [7:0]       csum_q, csum_d;
  logic             wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;

  logic             accept;
  logic [LEN_W-1:0] len_new;
  logic [LEN_W-1:0] idx_inc;
  logic [LEN_W+1:0] byte_addr;

  assign accept    = in_valid && in_ready;
  assign len_new   = {len_q[LEN_W-1:8], in_data};
  assign idx_inc   = idx_q + 1'b1;
  assign byte_addr = {idx_q, 2'b00};

  // State and datapath registers; synchronous active-low reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_LEN_HI;
      len_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      csum_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      csum_q    <= csum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state and datapath update; every field holds unless a byte is accepted.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          len_d   = {in_data, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = len_new;
          if (32'(len_new) > DEPTH_WORDS) begin
            state_d = S_ERR;
          end else if (len_new == '0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d  = csum_q ^ in_data;
          shift_d = {shift_q[15:0], in_data};
          cnt_d   = cnt_q + 2'd1;
          // Last byte of a word: the three earlier bytes sit in the shift register.
          if (cnt_q == 2'(WORD_BYTES - 1)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'(byte_addr);
            wr_data_d = {shift_q, in_data};
            idx_d     = idx_inc;
            if (idx_inc == len_q) begin
              state_d = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? S_DONE : S_ERR;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Status outputs decode from state alone; write port comes straight from registers.
  always_comb begin
    in_ready = 1'b0;
    cpu_run  = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: in_ready = 1'b1;
      S_DONE: begin
        cpu_run = 1'b1;
        done    = 1'b1;
      end
      S_ERR:   error = 1'b1;
      default: in_ready = 1'b0;
    endcase
    wr_en   = wr_en_q;
    wr_addr = wr_addr_q;
    wr_data = wr_data_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_run;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  int          cap_cyc[$];
  logic [31:0] img[$];

  imem_loader #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_W     (32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cpu_run (cpu_run),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
      cap_cyc.push_back(cyc);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output bit took);
    in_valid = 1'b0;
    repeat (gap) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    took     = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Send header n, the words in img, then csum; pre_done is sampled just before the csum byte.
  task automatic run_stream(input logic [15:0] n, input logic [7:0] csum, input int max_gap,
                            output logic pre_done);
    bit took;
    send_byte(n[15:8], $urandom_range(0, max_gap), took);
    send_byte(n[7:0], $urandom_range(0, max_gap), took);
    foreach (img[i]) begin
      for (int k = 3; k >= 0; k--) begin
        send_byte(img[i][8*k +: 8], $urandom_range(0, max_gap), took);
      end
    end
    in_valid = 1'b0;
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
    pre_done = done;
    send_byte(csum, 0, took);
  endtask

  function automatic logic [7:0] img_xor();
    logic [7:0] x = 8'h00;
    foreach (img[i]) x = x ^ img[i][31:24] ^ img[i][23:16] ^ img[i][15:8] ^ img[i][7:0];
    return x;
  endfunction

  // Model: a legal length writes word i at byte address 4*i; done iff the checksum matches.
  task automatic check_result(input string tag, input logic [15:0] n, input logic [7:0] csum);
    bit   len_bad  = (32'(n) > DEPTH);
    logic exp_done = !len_bad && (csum == img_xor());
    int   exp_cnt  = len_bad ? 0 : img.size();
    repeat (2) @(negedge clk);
    total++;
    if (cap_addr.size() !== exp_cnt) begin
      bad++;
      $display("FAIL %s write_count: got %0d want %0d", tag, cap_addr.size(), exp_cnt);
    end
    for (int i = 0; i < exp_cnt && i < cap_addr.size(); i++) begin
      total++;
      if (cap_addr[i] !== 32'(i * 4) || cap_data[i] !== img[i]) begin
        bad++;
        $display("FAIL %s write[%0d]: got %h@%h want %h@%h", tag, i, cap_data[i], cap_addr[i],
                 img[i], 32'(i * 4));
      end
    end
    total++;
    if ({done, cpu_run, error, in_ready} !== {exp_done, exp_done, !exp_done, 1'b0}) begin
      bad++;
      $display("FAIL %s status(done,run,err,rdy): got %b want %b", tag,
               {done, cpu_run, error, in_ready}, {exp_done, exp_done, !exp_done, 1'b0});
    end
  endtask

  // Hold reset with an optional byte offered; a misparsed 0xFF would corrupt the next load.
  task automatic apply_reset(input bit with_byte);
    reset    = 1'b0;
    in_valid = with_byte;
    in_data  = 8'hFF;
    repeat (2) @(negedge clk);
    total++;
    if ({wr_en, wr_addr, wr_data, cpu_run, done, error} !== 68'd0) begin
      bad++;
      $display("FAIL reset_outputs: got en=%b a=%h d=%h run=%b done=%b err=%b want all 0",
               wr_en, wr_addr, wr_data, cpu_run, done, error);
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    cap_addr.delete();
    cap_data.delete();
    cap_cyc.delete();
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
  endtask

  task automatic test_good_image();
    logic pre;
    apply_reset(1'b1);
    img = '{32'h20080005, 32'hAC080000};
    // XOR of 20 08 00 05 AC 08 00 00 is 0x89.
    run_stream(16'd2, 8'h89, 0, pre);
    total++;
    if (pre !== 1'b0) begin
      bad++;
      $display("FAIL good_done_early: got %b want 0", pre);
    end
    check_result("good_image", 16'd2, 8'h89);
  endtask

  task automatic test_bad_csum();
    logic pre;
    apply_reset(1'b0);
    img = '{32'h20080005, 32'hAC080000};
    run_stream(16'd2, 8'h00, 1, pre);
    check_result("bad_csum", 16'd2, 8'h00);
  endtask

  task automatic test_len_overflow();
    bit took;
    apply_reset(1'b0);
    send_byte(8'h01, 0, took);
    send_byte(8'h01, 0, took);
    total++;
    if (error !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL len_overflow_err: got err=%b rdy=%b want err=1 rdy=0", error, in_ready);
    end
    img = '{32'h11223344};
    repeat (4) send_byte(8'h55, 0, took);
    check_result("len_overflow", 16'h0101, 8'h55);
  endtask

  task automatic test_len_max();
    logic pre;
    apply_reset(1'b0);
    img.delete();
    for (int i = 0; i < int'(DEPTH); i++) img.push_back($urandom);
    run_stream(16'(DEPTH), img_xor(), 0, pre);
    check_result("len_max", 16'(DEPTH), img_xor());
  endtask

  task automatic test_empty();
    logic pre;
    apply_reset(1'b0);
    img.delete();
    run_stream(16'd0, 8'h00, 2, pre);
    check_result("empty", 16'd0, 8'h00);
  endtask

  task automatic test_gaps();
    logic pre;
    apply_reset(1'b0);
    img = '{32'h8C090004};
    run_stream(16'd1, img_xor(), 5, pre);
    check_result("gaps", 16'd1, img_xor());
  endtask

  task automatic test_back_to_back();
    logic pre;
    apply_reset(1'b0);
    img.delete();
    for (int i = 0; i < 4; i++) img.push_back($urandom);
    run_stream(16'd4, img_xor(), 0, pre);
    for (int i = 1; i < cap_cyc.size(); i++) begin
      total++;
      if (cap_cyc[i] - cap_cyc[i-1] !== 4) begin
        bad++;
        $display("FAIL b2b_spacing[%0d]: got %0d want 4", i, cap_cyc[i] - cap_cyc[i-1]);
      end
    end
    check_result("back_to_back", 16'd4, img_xor());
  endtask

  task automatic test_mid_reset();
    bit   took;
    logic pre;
    apply_reset(1'b0);
    img.delete();
    for (int i = 0; i < 3; i++) img.push_back($urandom);
    send_byte(8'h00, 0, took);
    send_byte(8'h03, 1, took);
    for (int k = 0; k < 6; k++) send_byte(img[k/4][8*(3 - k%4) +: 8], $urandom_range(0, 2), took);
    repeat (2) @(negedge clk);
    total++;
    if (cap_addr.size() !== 1 || cap_data.size() !== 1 || cap_addr[0] !== 32'h0 ||
        cap_data[0] !== img[0]) begin
      bad++;
      $display("FAIL mid_reset_partial: got %0d writes want 1 (%h@0)", cap_addr.size(), img[0]);
    end
    apply_reset(1'b1);
    repeat (3) @(negedge clk);
    total++;
    if (cap_addr.size() !== 0) begin
      bad++;
      $display("FAIL mid_reset_flush: got %0d writes want 0", cap_addr.size());
    end
    img.delete();
    for (int i = 0; i < 3; i++) img.push_back($urandom);
    run_stream(16'd3, img_xor(), 2, pre);
    check_result("mid_reset_reload", 16'd3, img_xor());
  endtask

  task automatic test_random();
    logic        pre;
    logic [15:0] n;
    logic [7:0]  cs;
    for (int t = 0; t < 20; t++) begin
      apply_reset($urandom_range(0, 1) == 1);
      img.delete();
      for (int i = 0; i < int'($urandom_range(0, 10)); i++) img.push_back($urandom);
      n = 16'(img.size());
      if ($urandom_range(0, 9) == 0) n = 16'($urandom_range(DEPTH + 1, 16'hFFFF));
      cs = img_xor();
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      run_stream(n, cs, $urandom_range(0, 3), pre);
      check_result($sformatf("random%0d", t), n, cs);
    end
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_good_image();
    test_bad_csum();
    test_len_overflow();
    test_len_max();
    test_empty();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
